// File: rtl/gate_tt_checker.sv
// Two-input gate truth-table checker: walks vectors 00..11, settles, samples y, tallies mismatches.
// Optional y_log capture is compiled in with `define GATE_TT_YLOG_EN.
module gate_tt_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  EXPECT        = 4'b1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic       y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [1:0] fail_vec,
  output logic [1:0] vec_idx,
  output logic [3:0] y_log
);

  // state  | meaning
  // IDLE   | waiting for start; results and last vector held
  // DRIVE  | vector applied, settle counter running down
  // SAMPLE | compare y_in against EXPECT[vec_idx]
  // DONE   | end of run; done/pass are registered out of this state
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] vec_q, vec_d;
  logic [1:0] ab_q, ab_d;
  logic [2:0] err_q, err_d;
  logic [1:0] fv_q, fv_d;
  logic       pass_q, pass_d;
  logic       done_q, done_d;
`ifdef GATE_TT_YLOG_EN
  logic [3:0] ylog_q, ylog_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    ab_d    = ab_q;
    err_d   = err_q;
    fv_d    = fv_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
`ifdef GATE_TT_YLOG_EN
    ylog_d  = ylog_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          cnt_d   = SETTLE_LOAD;
          vec_d   = 2'd0;
          ab_d    = 2'd0;
          err_d   = 3'd0;
          fv_d    = 2'd0;
          pass_d  = 1'b0;
`ifdef GATE_TT_YLOG_EN
          ylog_d  = 4'b0000;
`endif
        end
      end
      DRIVE: begin
        if (cnt_q == 8'd0) state_d = SAMPLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      SAMPLE: begin
        if (y_in != EXPECT[vec_q]) begin
          if (err_q < 3'd4) err_d = err_q + 3'd1;
          if (err_q == 3'd0) fv_d = vec_q;
        end
`ifdef GATE_TT_YLOG_EN
        ylog_d[vec_q] = y_in;
`endif
        if (vec_q != 2'd3) begin
          state_d = DRIVE;
          vec_d   = vec_q + 2'd1;
          ab_d    = vec_q + 2'd1;
          cnt_d   = SETTLE_LOAD;
        end else begin
          // a/b keep the last vector; only the index wraps
          state_d = DONE;
          vec_d   = 2'd0;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        pass_d  = (err_q == 3'd0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      vec_q   <= 2'd0;
      ab_q    <= 2'd0;
      err_q   <= 3'd0;
      fv_q    <= 2'd0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      ab_q    <= ab_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

`ifdef GATE_TT_YLOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ylog_q <= 4'b0000;
    else     ylog_q <= ylog_d;
  end
  assign y_log = ylog_q;
`else
  assign y_log = 4'b0000;
`endif

  assign {a_out, b_out} = ab_q;
  assign busy     = (state_q == DRIVE) || (state_q == SAMPLE);
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign fail_vec = fv_q;
  assign vec_idx  = vec_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Bench for gate_tt_checker: random gate responses scored against a truth-table model,
// plus directed start-hold, mid-run reset and OR-gate configuration runs.
module tb_gate_tt_checker;
  localparam int unsigned S1 = 2;
  localparam logic [3:0]  EXP1 = 4'b1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       a_out, b_out, y_in, busy, done, pass;
  logic [2:0] err_cnt;
  logic [1:0] fail_vec, vec_idx;
  logic [3:0] y_log;
  logic [3:0] resp_tbl = 4'b1000;

  logic       start2 = 1'b0;
  logic       a2, b2, y2, busy2, done2, pass2;
  logic [2:0] err2;
  logic [1:0] fv2, vec2;
  logic [3:0] ylog2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // gate under test modelled as a lookup indexed by the applied vector
  assign y_in = resp_tbl[{a_out, b_out}];
  assign y2   = a2 | b2;

  gate_tt_checker #(.SETTLE_CYCLES(S1), .EXPECT(EXP1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a_out(a_out), .b_out(b_out),
    .y_in(y_in), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_vec(fail_vec), .vec_idx(vec_idx), .y_log(y_log)
  );

  gate_tt_checker #(.SETTLE_CYCLES(1), .EXPECT(4'b1110)) u_or (
    .clk(clk), .rst(rst), .start(start2), .a_out(a2), .b_out(b2),
    .y_in(y2), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
    .fail_vec(fv2), .vec_idx(vec2), .y_log(ylog2)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [3:0] resp, input logic [3:0] expv,
                                output int err, output int fv, output logic ok,
                                output logic [3:0] ylog);
    err = 0;
    fv  = 0;
    for (int i = 0; i < 4; i++) begin
      if (resp[i] != expv[i]) begin
        if (err == 0) fv = i;
        err++;
      end
    end
    ok = (err == 0);
`ifdef GATE_TT_YLOG_EN
    ylog = resp;
`else
    ylog = 4'b0000;
`endif
  endfunction

  task automatic run_main(input logic [3:0] resp, input string tag);
    int         e_err, e_fv, lat;
    logic       e_ok;
    logic [3:0] e_ylog;
    resp_tbl = resp;
    model(resp, EXP1, e_err, e_fv, e_ok, e_ylog);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, " cleared"}, {busy, a_out, b_out, vec_idx, err_cnt, pass, y_log},
          {1'b1, 12'h000});
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    check({tag, " latency"}, 16'(lat), 16'(1 + 4 * (S1 + 1)));
    check({tag, " err_cnt"}, 16'(err_cnt), 16'(e_err));
    check({tag, " fail_vec"}, 16'(fail_vec), 16'(e_fv));
    check({tag, " pass"}, 16'(pass), 16'(e_ok));
    check({tag, " y_log"}, 16'(y_log), 16'(e_ylog));
    @(posedge clk);
    #1;
    check({tag, " idle"}, {done, busy, a_out, b_out, vec_idx}, 16'b0_0_1_1_00);
  endtask

  initial begin
    int bad_busy, n_done, lat;
    logic [3:0] r;

    #1;
    check("reset outputs", {a_out, b_out, busy, done, pass, err_cnt, fail_vec, vec_idx, y_log},
          16'h0000);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;

    run_main(4'b1000, "and");
    run_main(4'b0000, "stuck0");
    run_main(4'b1111, "stuck1");
    for (int n = 0; n < 6; n++) begin
      r = 4'($urandom_range(0, 15));
      run_main(r, $sformatf("rand%0d", n));
    end

    // start held for 20 cycles: only DONE and the following IDLE cycle show busy low
    resp_tbl = 4'b1000;
    bad_busy = 0;
    n_done   = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 19; k++) begin
      @(posedge clk);
      #1;
      if (busy !== !(k == 12 || k == 13)) bad_busy++;
      if (done) n_done++;
    end
    @(negedge clk) start = 1'b0;
    check("hold busy profile", 16'(bad_busy), 16'd0);
    check("hold done count", 16'(n_done), 16'd1);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check("hold second run", 16'(n_done), 16'd1);
    check("hold settles idle", 16'(busy), 16'd0);

    // reset while vector 2 is being driven
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (vec_idx == 2'd2 && busy) begin
        lat = k;
        break;
      end
    end
    check("reach vector 2", 16'(lat), 16'(2 * (S1 + 1)));
    @(negedge clk) rst = 1'b1;
    #1;
    check("mid-run reset", {a_out, b_out, busy, done, pass, err_cnt, fail_vec, vec_idx, y_log},
          16'h0000);
    @(negedge clk) rst = 1'b0;
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) n_done++;
    end
    check("no done after abort", 16'(n_done), 16'd0);
    run_main(4'b1000, "post-reset");

    // OR gate, one settle cycle
    @(negedge clk) start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done2) begin
        lat = k;
        break;
      end
    end
    check("or latency", 16'(lat), 16'(1 + 4 * (1 + 1)));
    check("or pass", {pass2, err2, fv2}, {10'd0, 1'b1, 3'd0, 2'd0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gate_tt_checker.md
GATE_TT_CHECKER -- requirements
Module: gate_tt_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: cycles each vector is held before y_in is sampled; legal range 1..255.
REQ-002 SHALL have parameter EXPECT, default 4'b1000: expected y per vector, bit i for vector i; the default is a 2-input AND.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request one full truth-table run.
REQ-006 SHALL have port a_out, output, 1 bit: drives gate input a.
REQ-007 SHALL have port b_out, output, 1 bit: drives gate input b.
REQ-008 SHALL have port y_in, input, 1 bit: observed gate output.
REQ-009 SHALL have port busy, output, 1 bit: run in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle end-of-run pulse.
REQ-011 SHALL have port pass, output, 1 bit: last run had zero mismatches.
REQ-012 SHALL have port err_cnt, output, 3 bits: mismatch count of the last run, 0..4.
REQ-013 SHALL have port fail_vec, output, 2 bits: index of the first mismatching vector (0 if none).
REQ-014 SHALL have port vec_idx, output, 2 bits: current vector index.
REQ-015 SHALL have port y_log, output, 4 bits: sampled y per vector (see Configuration).

Function
REQ-016 SHALL implement FSM states IDLE, DRIVE, SAMPLE, DONE.
REQ-017 SHALL accept start only in IDLE; start in DRIVE, SAMPLE or DONE SHALL be ignored.
REQ-018 SHALL, on start in IDLE, enter DRIVE next cycle with vec_idx=0, a_out=0, b_out=0, and clear err_cnt, fail_vec, pass and y_log.
REQ-019 SHALL drive {a_out,b_out}=vec_idx, giving vector order 00, 01, 10, 11.
REQ-020 SHALL remain in DRIVE for exactly SETTLE_CYCLES cycles using an 8-bit settle counter, then enter SAMPLE.
REQ-021 SHALL, in SAMPLE (one cycle), compare y_in with EXPECT[vec_idx]; on mismatch it SHALL increment err_cnt and, if this is the first mismatch, load fail_vec=vec_idx.
REQ-022 SHALL, from SAMPLE, go to DRIVE with vec_idx+1 if vec_idx<3; otherwise go to DONE with vec_idx wrapping to 0.
REQ-023 SHALL assert busy in DRIVE and SAMPLE only.
REQ-024 SHALL, in DONE, assert done for one cycle, set pass=(err_cnt==0), and return to IDLE.
REQ-025 SHALL place the done pulse 1+4*(SETTLE_CYCLES+1) cycles after the start-sampling edge (13 cycles for the default).
REQ-026 SHALL hold pass, err_cnt, fail_vec and y_log in IDLE until the next accepted start.
REQ-027 SHALL hold a_out and b_out at their last vector value in IDLE.
REQ-028 SHALL saturate err_cnt at 4; it cannot exceed 4 by construction.

Reset
REQ-029 SHALL, while rst=1, immediately force IDLE, with a_out, b_out, busy, done, pass, err_cnt, fail_vec, vec_idx, y_log and the settle counter all 0.
REQ-030 SHALL, on rst during a run, abort the run with no done pulse; the first start after rst deasserts SHALL run all four vectors.

Configuration
REQ-031 SHALL compile the y_log feature when macro GATE_TT_YLOG_EN is defined: in SAMPLE, y_log[vec_idx] is loaded with y_in.
REQ-032 SHALL, when GATE_TT_YLOG_EN is undefined, keep the y_log port with no storage and tie it to 4'b0000; all other behaviour is identical.

Verification
REQ-033 SHALL pass scenario 1: y_in=a_out&b_out, defaults, start pulse -> done 13 cycles later, pass=1, err_cnt=0, fail_vec=0, y_log=4'b1000 (macro on).
REQ-034 SHALL pass scenario 2: y_in stuck at 0 -> err_cnt=1, fail_vec=3, pass=0.
REQ-035 SHALL pass scenario 3: y_in stuck at 1 -> err_cnt=3, fail_vec=0, pass=0, y_log=4'b1111 (macro on), 4'b0000 (macro off).
REQ-036 SHALL pass scenario 4: start held high for 20 cycles from IDLE -> exactly one run, with busy low only in DONE and the following cycles; a second run starts only after the return to IDLE.
REQ-037 SHALL pass scenario 5: rst pulsed during DRIVE of vector 2 -> all outputs 0 at once, no done; a new start gives a full 13-cycle run with a correct result.
REQ-038 SHALL pass scenario 6: EXPECT=4'b1110, SETTLE_CYCLES=1, y_in=a_out|b_out -> done 9 cycles after start, pass=1.
